clock_set_ctrl: RTL

- Time-setting front end for the 12-hour digital clock.
- Debounces two raw active-low push-buttons (MODE, INC) and runs an edit state machine (hour, then minute).
- Drives BCD load data and one-cycle load strobes into the hour, minute, second and AM/PM counters.
- Gates normal time-keeping via run_en and provides blink enables for the display stage.

---
 rtl/clock_set_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: debounced two-key time-setting front end for a 12-hour clock
module clock_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_mode_n,
    input  logic       key_inc_n,
    input  logic [7:0] hour_in,
    input  logic [7:0] min_in,
    input  logic       ampm_in,
    output logic [7:0] hour_data,
    output logic [7:0] min_data,
    output logic [7:0] sec_data,
    output logic       ampm_data,
    output logic       load_hour,
    output logic       load_min,
    output logic       load_sec,
    output logic       load_ampm,
    output logic       run_en,
    output logic       blink_hour,
    output logic       blink_min
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {RUN, EDIT_HOUR, EDIT_MIN, COMMIT} state_t;

    state_t        state, state_nx;
    logic [1:0]    s1, s2, prev, db, armed, press;
    logic [DW-1:0] cnt [2];
    logic [BW-1:0] bcnt;
    logic          phase, mode_press, inc_press, enter_edit;
    logic [7:0]    edit_hour, edit_min;
    logic          edit_ampm;

    function automatic logic [7:0] valid_hour(input logic [7:0] h);
        return ((h[7:4] == 4'd0 && h[3:0] >= 4'd1 && h[3:0] <= 4'd9) ||
                (h[7:4] == 4'd1 && h[3:0] <= 4'd2)) ? h : 8'h12;
    endfunction

    function automatic logic [7:0] valid_min(input logic [7:0] m);
        return (m[7:4] <= 4'd5 && m[3:0] <= 4'd9) ? m : 8'h00;
    endfunction

    function automatic logic [7:0] inc_hour(input logic [7:0] h);
        return h == 8'h12 ? 8'h01 : h == 8'h09 ? 8'h10 : {h[7:4], h[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_min(input logic [7:0] m);
        return m[3:0] == 4'd9 ? (m[7:4] == 4'd5 ? 8'h00 : {m[7:4] + 4'd1, 4'h0})
                              : {m[7:4], m[3:0] + 4'd1};
    endfunction

    assign mode_press = press[0];
    assign inc_press  = press[1];

    // Two-stage synchronizer plus a delayed copy to detect level changes
    always_ff @(posedge clk) begin
        s1   <= {key_inc_n, key_mode_n};
        s2   <= s1;
        prev <= s2;
    end

    // Debounce each key; a press is only armed once the key has been seen stably released
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            press[k] <= 1'b0;
            if (reset) begin
                cnt[k]   <= '0;
                db[k]    <= 1'b1;
                armed[k] <= 1'b0;
            end else if (s2[k] != prev[k]) begin
                cnt[k] <= '0;
            end else if (cnt[k] != DMAX) begin
                cnt[k] <= cnt[k] + 1'b1;
            end else begin
                if (s2[k]) armed[k] <= 1'b1;
                if (s2[k] != db[k]) begin
                    db[k]    <= s2[k];
                    press[k] <= ~s2[k] & armed[k];
                end
            end
        end
    end

    // Edit state register
    always_ff @(posedge clk) begin
        state <= reset ? RUN : state_nx;
    end

    // Next state: mode advances the edit sequence, commit lasts one cycle
    always_comb begin
        state_nx = state;
        case (state)
            RUN:       state_nx = mode_press ? EDIT_HOUR : RUN;
            EDIT_HOUR: state_nx = mode_press ? EDIT_MIN : EDIT_HOUR;
            EDIT_MIN:  state_nx = mode_press ? COMMIT : EDIT_MIN;
            default:   state_nx = RUN;
        endcase
    end

    // Capture current time on entry to edit, then apply inc presses to the active field
    always_ff @(posedge clk) begin
        if (reset) begin
            edit_hour <= 8'h12;
            edit_min  <= 8'h00;
            edit_ampm <= 1'b0;
        end else if (state == RUN && mode_press) begin
            edit_hour <= valid_hour(hour_in);
            edit_min  <= valid_min(min_in);
            edit_ampm <= ampm_in;
        end else if (inc_press && !mode_press && state == EDIT_HOUR) begin
            edit_hour <= inc_hour(edit_hour);
            edit_ampm <= edit_ampm ^ (edit_hour == 8'h11);
        end else if (inc_press && !mode_press && state == EDIT_MIN) begin
            edit_min <= inc_min(edit_min);
        end
    end

    assign enter_edit = state_nx != state && (state_nx == EDIT_HOUR || state_nx == EDIT_MIN);

    // Blink phase generator, restarted visible on entry to each edit field
    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (enter_edit) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (bcnt == BMAX) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    assign hour_data  = edit_hour;
    assign min_data   = edit_min;
    assign ampm_data  = edit_ampm;
    assign sec_data   = 8'h00;
    assign load_hour  = state == COMMIT;
    assign load_min   = state == COMMIT;
    assign load_sec   = state == COMMIT;
    assign load_ampm  = state == COMMIT;
    assign run_en     = state == RUN;
    assign blink_hour = state == EDIT_HOUR && !phase;
    assign blink_min  = state == EDIT_MIN && !phase;
endmodule
